inst_prefetch_buffer: RTL and testbench



---
 rtl/inst_prefetch_buffer_if.sv | 29 ++
 rtl/inst_prefetch_buffer.sv | 114 +++++++++++
 tb/tb_inst_prefetch_buffer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_buffer_if.sv
// Instruction-memory fetch bus between the prefetch buffer (master) and the instruction SRAM (slave).
// A request transfers on a clock edge where mem_req_valid && mem_req_ready are both high; the
// master holds mem_addr stable while waiting. Exactly one mem_rsp_valid pulse returns per accepted
// request, in order, and it carries no ready (the master always takes or discards it).
interface inst_prefetch_buffer_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// RV32I fetch front end: one outstanding word fetch feeding a small {pc, inst} FIFO whose head
// drives Reg_D. A redirect flushes the FIFO and drops any response still in flight.
module inst_prefetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  input  logic                          stall,
  output logic                          out_valid,
  output logic [31:0]                   out_pc,
  output logic [31:0]                   out_inst,
  inst_prefetch_buffer_if.master        bus,
  output logic [1:0]                    dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [31:0]       pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];

  logic req_fire;
  logic push;
  logic pop;

  assign dbg_state = state;
  assign bus.mem_addr = fetch_pc[ADDR_W-1:0];

  always_comb begin
    state_next        = state;
    bus.mem_req_valid = 1'b0;
    push              = 1'b0;
    case (state)
      IDLE: begin
        // Only IDLE requests; the slot for an in-flight word is reserved by count < DEPTH here.
        bus.mem_req_valid = !rst && !redirect && (count < CNT_W'(DEPTH));
        if (bus.mem_req_valid && bus.mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_next = bus.mem_rsp_valid ? IDLE : DROP;
        end else if (bus.mem_rsp_valid) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      DROP: begin
        if (bus.mem_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && !stall && !redirect;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign out_inst  = out_valid ? inst_mem[rd_ptr] : NOP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= 32'h0;
      req_pc   <= 32'h0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        // Flush wins over any push/pop this cycle; the target is forced word-aligned.
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= bus.mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench for inst_prefetch_buffer: a behavioural instruction memory answers each accepted
// request with 0x1000_0000 + addr after a programmable delay; checks run at the falling edge.
module tb_inst_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rsp_delay;

  logic        pend;
  logic [15:0] pend_addr;
  int          pend_cnt;

  inst_prefetch_buffer_if #(.ADDR_W(16)) bus ();

  inst_prefetch_buffer #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .bus         (bus),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: notes handshakes at the falling edge, drives the response just after a rising edge.
  initial begin : mem_model
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
    pend      = 1'b0;
    pend_addr = '0;
    pend_cnt  = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_rsp_valid) pend = 1'b0;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        pend      = 1'b1;
        pend_addr = bus.mem_addr;
        pend_cnt  = rsp_delay;
      end
      @(posedge clk);
      #1;
      bus.mem_rsp_valid = 1'b0;
      if (pend) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = 32'h1000_0000 + {16'h0, pend_addr};
        end
      end
    end
  end

  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return {30'h0, dbg_state};
  endfunction

  function automatic logic [31:0] addr();
    return {16'h0, bus.mem_addr};
  endfunction

  initial begin
    rst               = 1'b1;
    stall             = 1'b0;
    redirect          = 1'b0;
    redirect_pc       = 32'h0;
    bus.mem_req_ready = 1'b1;
    rsp_delay         = 1;

    repeat (2) @(posedge clk);
    #1;
    mid();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0000_0013);
    chk("rst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("rst_state", st(), 32'h0);
    cyc = -1;

    // Fill with stall held from the first fetch: requests 0,4,8,C one every two cycles.
    go(0); rst = 1'b0; stall = 1'b1; mid();
    chk("c0_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("c0_addr", addr(), 32'h0);
    chk("c0_out_valid", {31'h0, out_valid}, 32'h0);
    go(1); mid();
    chk("c1_state_wait", st(), 32'h1);
    chk("c1_req_low", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("c1_out_valid", {31'h0, out_valid}, 32'h0);
    go(2); mid();
    chk("c2_out_valid", {31'h0, out_valid}, 32'h1);
    chk("c2_out_pc", out_pc, 32'h0);
    chk("c2_out_inst", out_inst, 32'h1000_0000);
    chk("c2_addr", addr(), 32'h4);
    go(4); mid();
    chk("c4_addr", addr(), 32'h8);
    go(6); mid();
    chk("c6_addr", addr(), 32'hC);
    go(8); mid();
    chk("c8_full_req_low", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("c8_out_pc", out_pc, 32'h0);
    go(19); mid();
    chk("c19_full_req_low", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("c19_out_valid", {31'h0, out_valid}, 32'h1);
    chk("c19_state_idle", st(), 32'h0);

    // Release stall: pops 0,4,8,C back to back, fetching resumes at 0x10.
    go(20); stall = 1'b0; mid();
    chk("c20_out_pc", out_pc, 32'h0);
    chk("c20_req_low", {31'h0, bus.mem_req_valid}, 32'h0);
    go(21); mid();
    chk("c21_out_pc", out_pc, 32'h4);
    chk("c21_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("c21_addr", addr(), 32'h10);
    go(22); mid();
    chk("c22_out_pc", out_pc, 32'h8);
    go(23); mid();
    chk("c23_out_pc", out_pc, 32'hC);
    chk("c23_addr", addr(), 32'h14);
    go(24); mid();
    chk("c24_out_pc", out_pc, 32'h10);
    chk("c24_out_inst", out_inst, 32'h1000_0010);
    go(25); rsp_delay = 3; mid();
    chk("c25_out_pc", out_pc, 32'h14);
    chk("c25_addr", addr(), 32'h18);

    // Redirect in WAIT, stale response arrives later and must be dropped.
    go(26); redirect = 1'b1; redirect_pc = 32'h0000_0102; mid();
    chk("c26_out_valid", {31'h0, out_valid}, 32'h0);
    chk("c26_req_low", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("c26_state_wait", st(), 32'h1);
    go(27); redirect = 1'b0; mid();
    chk("c27_state_drop", st(), 32'h2);
    chk("c27_req_low", {31'h0, bus.mem_req_valid}, 32'h0);
    go(28); mid();
    chk("c28_state_drop", st(), 32'h2);
    chk("c28_out_valid", {31'h0, out_valid}, 32'h0);
    go(29); rsp_delay = 1; mid();
    chk("c29_state_idle", st(), 32'h0);
    chk("c29_out_valid", {31'h0, out_valid}, 32'h0);
    chk("c29_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("c29_addr", addr(), 32'h100);
    go(30); mid();
    chk("c30_state_wait", st(), 32'h1);
    go(31); stall = 1'b1; mid();
    chk("c31_out_valid", {31'h0, out_valid}, 32'h1);
    chk("c31_out_pc", out_pc, 32'h100);
    chk("c31_out_inst", out_inst, 32'h1000_0100);
    chk("c31_addr", addr(), 32'h104);

    // Redirect coincides with a response and a would-be pop.
    go(32); stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200; mid();
    chk("c32_out_valid", {31'h0, out_valid}, 32'h1);
    chk("c32_out_pc", out_pc, 32'h100);
    chk("c32_state_wait", st(), 32'h1);
    go(33); redirect = 1'b0; mid();
    chk("c33_out_valid", {31'h0, out_valid}, 32'h0);
    chk("c33_state_idle", st(), 32'h0);
    chk("c33_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("c33_addr", addr(), 32'h200);
    go(34); mid();
    chk("c34_state_wait", st(), 32'h1);

    // Memory not ready for five cycles: request held stable.
    go(35); bus.mem_req_ready = 1'b0; mid();
    chk("c35_out_pc", out_pc, 32'h200);
    chk("c35_out_inst", out_inst, 32'h1000_0200);
    chk("c35_addr", addr(), 32'h204);
    go(37); mid();
    chk("c37_out_valid", {31'h0, out_valid}, 32'h0);
    chk("c37_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("c37_addr", addr(), 32'h204);
    go(39); mid();
    chk("c39_addr", addr(), 32'h204);
    chk("c39_state_idle", st(), 32'h0);
    go(40); bus.mem_req_ready = 1'b1; mid();
    chk("c40_addr", addr(), 32'h204);
    go(41); mid();
    chk("c41_state_wait", st(), 32'h1);
    go(42); stall = 1'b1; mid();
    chk("c42_out_pc", out_pc, 32'h204);
    chk("c42_out_inst", out_inst, 32'h1000_0204);
    chk("c42_addr", addr(), 32'h208);

    // Reset in WAIT with three entries buffered, late response afterwards is ignored.
    go(46); rsp_delay = 4; mid();
    chk("c46_out_pc", out_pc, 32'h204);
    chk("c46_addr", addr(), 32'h210);
    chk("c46_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    go(47); rst = 1'b1; bus.mem_req_ready = 1'b0; mid();
    chk("c47_state_wait", st(), 32'h1);
    go(48); mid();
    chk("c48_out_valid", {31'h0, out_valid}, 32'h0);
    chk("c48_out_inst", out_inst, 32'h0000_0013);
    chk("c48_req_low", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("c48_state_idle", st(), 32'h0);
    go(49); rst = 1'b0; mid();
    chk("c49_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("c49_addr", addr(), 32'h0);
    go(50); mid();
    chk("c50_late_rsp_state", st(), 32'h0);
    chk("c50_out_valid", {31'h0, out_valid}, 32'h0);
    go(51); bus.mem_req_ready = 1'b1; rsp_delay = 1; stall = 1'b0; mid();
    chk("c51_out_valid", {31'h0, out_valid}, 32'h0);
    chk("c51_out_inst", out_inst, 32'h0000_0013);
    chk("c51_addr", addr(), 32'h0);
    go(52); mid();
    chk("c52_state_wait", st(), 32'h1);
    go(53); mid();
    chk("c53_out_valid", {31'h0, out_valid}, 32'h1);
    chk("c53_out_pc", out_pc, 32'h0);
    chk("c53_out_inst", out_inst, 32'h1000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
